// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out serializer.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_e;

    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter: takes a WIDTH-bit word on a valid/ready handshake
// and streams it one bit per clock, reloading on the last bit for gapless words.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             par_valid_i,
    output logic             par_ready_o,
    input  logic [WIDTH-1:0] par_data_i,
    output logic             ser_o,
    output logic             ser_valid_o,
    output logic             ser_last_o,
    output logic             busy_o
);

    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] CNT_PEN = CW'(WIDTH - 2);

    // Handshake: a word transfers on a rising edge where par_valid_i && par_ready_o;
    // par_ready_o depends only on registered state and rstn, never on par_valid_i.
    piso_state_e      r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_shift;
    logic             r_last;

    logic             w_xfer;
    logic [WIDTH-1:0] w_shift_nxt;

    assign par_ready_o = rstn && ((r_state == IDLE) || r_last);
    assign w_xfer      = par_valid_i && par_ready_o;

    // Shifted-out positions fill with 0, so the register is empty once a word ends.
    assign w_shift_nxt = (MSB_FIRST != 0) ? {r_shift[WIDTH-2:0], 1'b0}
                                          : {1'b0, r_shift[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_last  <= 1'b0;
        end else if (w_xfer) begin
            r_state <= SHIFT;
            r_cnt   <= '0;
            r_shift <= par_data_i;
            r_last  <= 1'b0;
        end else if (r_state == SHIFT) begin
            r_shift <= w_shift_nxt;
            if (r_last) begin
                r_state <= IDLE;
                r_cnt   <= '0;
                r_last  <= 1'b0;
            end else begin
                r_cnt  <= r_cnt + CW'(1);
                r_last <= (r_cnt == CNT_PEN);
            end
        end
    end

    assign ser_o       = (MSB_FIRST != 0) ? r_shift[WIDTH-1] : r_shift[0];
    assign ser_valid_o = (r_state == SHIFT);
    assign busy_o      = (r_state == SHIFT);
    assign ser_last_o  = r_last;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: LSB-first and MSB-first instances share inputs.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       par_valid = 1'b0;
    logic [3:0] par_data = 4'h0;

    logic rdy_l, ser_l, sv_l, sl_l, bsy_l;
    logic rdy_m, ser_m, sv_m, sl_m, bsy_m;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(4), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rstn(rstn), .par_valid_i(par_valid), .par_ready_o(rdy_l),
        .par_data_i(par_data), .ser_o(ser_l), .ser_valid_o(sv_l),
        .ser_last_o(sl_l), .busy_o(bsy_l)
    );

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rstn(rstn), .par_valid_i(par_valid), .par_ready_o(rdy_m),
        .par_data_i(par_data), .ser_o(ser_m), .ser_valid_o(sv_m),
        .ser_last_o(sl_m), .busy_o(bsy_m)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       vld;
        logic [3:0] dat;
        logic       sl;
        logic       sm;
        logic       v;
        logic       l;
        logic       r;
        logic       b;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic vld, logic [3:0] dat, logic sl, logic sm,
                                logic v, logic l, logic r, logic b);
        vec_t t;
        t.vld = vld; t.dat = dat; t.sl = sl; t.sm = sm;
        t.v = v; t.l = l; t.r = r; t.b = b;
        return t;
    endfunction

    // Loopback scoreboard: serial-in shift registers capture each word on ser_last.
    logic [3:0] exp_q[$];
    logic       lb_en = 1'b0;
    logic [3:0] sipo_l = 4'h0;
    logic [3:0] sipo_m = 4'h0;
    int         n_rx = 0;

    always @(negedge clk) begin
        if (lb_en && sv_l) begin
            if (sl_l) begin
                if (exp_q.size() == 0) begin
                    check("loop_unexpected_word", 32'(n_rx), 32'hFFFF_FFFF);
                end else begin
                    logic [3:0] e;
                    e = exp_q.pop_front();
                    check("loop_lsb_word", 32'({ser_l, sipo_l[3:1]}), 32'(e));
                    check("loop_msb_word", 32'({sipo_m[2:0], ser_m}), 32'(e));
                    check("loop_msb_last_aligned", 32'(sl_m), 32'(1'b1));
                end
                n_rx++;
            end
            sipo_l = {ser_l, sipo_l[3:1]};
            sipo_m = {sipo_m[2:0], ser_m};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] e_l;
        logic [3:0] e_m;
        logic [3:0] w;
        int         guard;

        // Reset state while rstn is low
        #3;
        check("reset_lsb_outs", 32'({rdy_l, ser_l, sv_l, sl_l, bsy_l}), 32'h0);
        check("reset_msb_outs", 32'({rdy_m, ser_m, sv_m, sl_m, bsy_m}), 32'h0);
        #9 rstn = 1'b1;
        step();
        step();
        check("post_reset_ready", 32'({rdy_l, rdy_m}), 32'h3);

        // 4'b1011 single word: LSB 1,1,0,1 / MSB 1,0,1,1
        tbl.push_back(mk(1, 4'hB, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 4'h0, 1, 1, 1, 0, 0, 1));
        tbl.push_back(mk(0, 4'h0, 1, 0, 1, 0, 0, 1));
        tbl.push_back(mk(0, 4'h0, 0, 1, 1, 0, 0, 1));
        tbl.push_back(mk(0, 4'h0, 1, 1, 1, 1, 1, 1));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 0, 1, 0));
        // back-to-back 4'hA then 4'h5 with valid held
        tbl.push_back(mk(1, 4'hA, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 4'h5, 0, 1, 1, 0, 0, 1));
        tbl.push_back(mk(1, 4'h5, 1, 0, 1, 0, 0, 1));
        tbl.push_back(mk(1, 4'h5, 0, 1, 1, 0, 0, 1));
        tbl.push_back(mk(1, 4'h5, 1, 0, 1, 1, 1, 1));
        tbl.push_back(mk(0, 4'h0, 1, 0, 1, 0, 0, 1));
        tbl.push_back(mk(0, 4'h0, 0, 1, 1, 0, 0, 1));
        tbl.push_back(mk(0, 4'h0, 1, 0, 1, 0, 0, 1));
        tbl.push_back(mk(0, 4'h0, 0, 1, 1, 1, 1, 1));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 0, 1, 0));
        // 4'hF offered while 4'h0 shifts; accepted only on the last-bit cycle
        tbl.push_back(mk(1, 4'h0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 4'hF, 0, 0, 1, 0, 0, 1));
        tbl.push_back(mk(1, 4'hF, 0, 0, 1, 0, 0, 1));
        tbl.push_back(mk(1, 4'hF, 0, 0, 1, 0, 0, 1));
        tbl.push_back(mk(1, 4'hF, 0, 0, 1, 1, 1, 1));
        tbl.push_back(mk(0, 4'h0, 1, 1, 1, 0, 0, 1));
        tbl.push_back(mk(0, 4'h0, 1, 1, 1, 0, 0, 1));
        tbl.push_back(mk(0, 4'h0, 1, 1, 1, 0, 0, 1));
        tbl.push_back(mk(0, 4'h0, 1, 1, 1, 1, 1, 1));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 0, 1, 0));

        foreach (tbl[i]) begin
            par_valid = tbl[i].vld;
            par_data  = tbl[i].dat;
            check($sformatf("vec%0d_lsb", i), 32'({ser_l, sv_l, sl_l, rdy_l, bsy_l}),
                  32'({tbl[i].sl, tbl[i].v, tbl[i].l, tbl[i].r, tbl[i].b}));
            check($sformatf("vec%0d_msb", i), 32'({ser_m, sv_m, sl_m, rdy_m, bsy_m}),
                  32'({tbl[i].sm, tbl[i].v, tbl[i].l, tbl[i].r, tbl[i].b}));
            step();
        end

        // Asynchronous reset mid-word of 4'hC
        par_valid = 1'b1;
        par_data  = 4'hC;
        step();
        par_valid = 1'b0;
        step();
        step();
        check("rst_mid_bit2", 32'({ser_l, ser_m, sv_l, sv_m}), 32'b1011);
        rstn = 1'b0;
        #1;
        check("rst_mid_lsb_outs", 32'({rdy_l, ser_l, sv_l, sl_l, bsy_l}), 32'h0);
        check("rst_mid_msb_outs", 32'({rdy_m, ser_m, sv_m, sl_m, bsy_m}), 32'h0);
        #2 rstn = 1'b1;
        #1;
        check("rst_release_state", 32'({rdy_l, rdy_m, bsy_l, bsy_m, sv_l}), 32'b11000);
        par_valid = 1'b1;
        par_data  = 4'h3;
        step();
        par_valid = 1'b0;
        e_l = 4'b0011;
        e_m = 4'b1100;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("after_rst_bit%0d", k), 32'({ser_l, ser_m, sv_l, sl_l, sl_m}),
                  32'({e_l[k], e_m[k], 1'b1, k == 3, k == 3}));
            step();
        end
        check("after_rst_idle", 32'({sv_l, sv_m, ser_l, ser_m, rdy_l}), 32'b00001);

        // Random loopback, with occasional idle gaps
        lb_en = 1'b1;
        for (int n = 0; n < 100; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                par_valid = 1'b0;
                repeat ($urandom_range(1, 5)) step();
            end
            w = 4'($urandom_range(0, 15));
            par_valid = 1'b1;
            par_data  = w;
            guard = 0;
            while (!rdy_l && guard < 20) begin
                step();
                guard++;
            end
            if (guard >= 20) check("loop_ready_timeout", 32'(n), 32'hFFFF_FFFF);
            exp_q.push_back(w);
            step();
        end
        par_valid = 1'b0;
        repeat (8) step();
        lb_en = 1'b0;
        check("loop_rx_count", 32'(n_rx), 32'd100);
        check("loop_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
